// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 10;
    localparam int BLOCK_W        = 128;
    localparam int BLOCK_OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_I;
        if (req0 && req1) begin
            winner = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req1) begin
            winner = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises block reads/write-throughs from the I-cache (port 0) and D-cache
// (port 1) onto one memory port, with a watchdog on stalled memory.
module mem_arbiter #(
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int BLOCK_W = mem_arb_pkg::BLOCK_W,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               rw0,
    input  logic               rw1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [BLOCK_W-1:0] wdata0,
    input  logic [BLOCK_W-1:0] wdata1,
    output logic               ack0,
    output logic               ack1,
    output logic               err0,
    output logic               err1,
    output logic [BLOCK_W-1:0] rdata0,
    output logic [BLOCK_W-1:0] rdata1,
    output logic               mem_req,
    output logic               mem_read_write,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready
);
    import mem_arb_pkg::*;

    localparam int              CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              WDOG_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_W) - 1);

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BLOCK_W-1:0] rdata0_q, rdata0_d;
    logic [BLOCK_W-1:0] rdata1_q, rdata1_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               err0_q, err0_d;
    logic               err1_q, err1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick;
    logic               pick_vld;

    rr_arbiter2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .winner     (pick),
        .valid      (pick_vld)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        cnt_d        = cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    mem_req_d    = 1'b1;
                    cnt_d        = '0;
                    state_d      = BUSY;
                    if (pick == PORT_D) begin
                        mem_rw_d    = rw1;
                        mem_addr_d  = addr1 & ALIGN_MASK;
                        mem_wdata_d = wdata1;
                    end else begin
                        mem_rw_d    = rw0;
                        mem_addr_d  = addr0 & ALIGN_MASK;
                        mem_wdata_d = wdata0;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (grant_q == PORT_D) begin
                        ack1_d = 1'b1;
                        if (!mem_rw_q) rdata1_d = mem_rdata;
                    end else begin
                        ack0_d = 1'b1;
                        if (!mem_rw_q) rdata0_d = mem_rdata;
                    end
                end else if (WDOG_EN && cnt_q == CNT_LAST) begin
                    // Stalled memory: complete with error and a zero block.
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (grant_q == PORT_D) begin
                        ack1_d   = 1'b1;
                        err1_d   = 1'b1;
                        rdata1_d = '0;
                    end else begin
                        ack0_d   = 1'b1;
                        err0_d   = 1'b1;
                        rdata0_d = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= PORT_I;
            last_grant_q <= PORT_D;
            mem_req_q    <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign err0           = err0_q;
    assign err1           = err1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign mem_req        = mem_req_q;
    assign mem_read_write = mem_rw_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: memory model, issue/completion queues,
// directed scenarios for arbitration, write-through, watchdog and reset.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int BW = 128;
    localparam int TO = 16;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [BW-1:0] wd;
    } iss_t;

    typedef struct packed {
        logic          port;
        logic          err;
        logic [BW-1:0] rd;
    } done_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [BW-1:0] rdata0, rdata1;
    logic          mem_req, mem_read_write;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata;
    logic          mem_ready;

    logic [BW-1:0] mem_blk [64];
    int            mem_lat   = 0;
    logic          mem_stall = 1'b0;

    iss_t          exp_iss  [$];
    done_t         exp_done [$];

    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    int            last_busy_len = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (AW),
        .BLOCK_W (BW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0),
        .req1           (req1),
        .rw0            (rw0),
        .rw1            (rw1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .ack0           (ack0),
        .ack1           (ack1),
        .err0           (err0),
        .err1           (err1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_req        (mem_req),
        .mem_read_write (mem_read_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready)
    );

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] pattern_blk();
        logic [BW-1:0] p;
        for (int k = 0; k < 16; k++) p[k*8 +: 8] = 8'(k);
        return p;
    endfunction

    // Memory model: answers mem_req after mem_lat idle cycles unless stalled.
    initial begin
        int lat_cnt;
        lat_cnt   = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem_blk[i] = {4{32'(i) * 32'h9E3779B1}};
        mem_blk[0] = pattern_blk();
        forever begin
            @(negedge clk);
            if (mem_req && !mem_stall) begin
                if (lat_cnt >= mem_lat) begin
                    if (mem_read_write) mem_blk[mem_addr[9:4]] = mem_wdata;
                    mem_rdata = mem_blk[mem_addr[9:4]];
                    mem_ready = 1'b1;
                end else begin
                    lat_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = {4{32'hDEADBEEF}};
                if (!mem_req) lat_cnt = 0;
            end
        end
    end

    // Monitor: checks each issue and each completion against the queues.
    initial begin
        iss_t  ie;
        done_t de;
        logic  req_prev, ack_prev, have_rise;
        logic [AW-1:0] cur_addr;
        int    last_rise, busy_cnt;
        req_prev = 0; ack_prev = 0; have_rise = 0; cur_addr = '0;
        last_rise = 0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                req_prev = 0;
                ack_prev = 0;
            end else begin
                if (mem_req && !req_prev) begin
                    if (exp_iss.size() == 0) begin
                        chk("issue_unexpected", 1, 0);
                    end else begin
                        ie = exp_iss.pop_front();
                        chk("mem_rw", mem_read_write, ie.rw);
                        chk("mem_addr", mem_addr, ie.addr);
                        chk("mem_wdata", mem_wdata, ie.wd);
                        cur_addr = ie.addr;
                    end
                    if (have_rise) chk("issue_gap_ge3", (cyc - last_rise) >= 3, 1);
                    have_rise = 1;
                    last_rise = cyc;
                    busy_cnt  = 1;
                end else if (mem_req) begin
                    chk("mem_addr_stable", mem_addr, cur_addr);
                    busy_cnt++;
                end
                if (!mem_req && req_prev) last_busy_len = busy_cnt;
                if (ack0 || ack1) begin
                    chk("ack_exclusive", ack0 & ack1, 0);
                    chk("ack_single_pulse", ack_prev, 0);
                    if (exp_done.size() == 0) begin
                        chk("ack_unexpected", 1, 0);
                    end else begin
                        de = exp_done.pop_front();
                        chk("ack_port", ack1, de.port);
                        chk("err", de.port ? err1 : err0, de.err);
                        chk("err_other_port", de.port ? err0 : err1, 0);
                        chk("rdata", de.port ? rdata1 : rdata0, de.rd);
                    end
                end else begin
                    chk("err_without_ack", err0 | err1, 0);
                end
                req_prev = mem_req;
                ack_prev = ack0 | ack1;
            end
        end
    end

    task automatic wait_ack(input logic port, input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (port ? ack1 : ack0) got = 1;
        end
        chk(tag, got, 1);
    endtask

    task automatic do_req(input logic port, input logic rw, input logic [AW-1:0] addr,
                          input logic [BW-1:0] wd, input logic [BW-1:0] exp_rd,
                          input logic exp_err);
        @(negedge clk);
        exp_iss.push_back('{rw: rw, addr: addr & 10'h3F0, wd: wd});
        exp_done.push_back('{port: port, err: exp_err, rd: exp_rd});
        if (port) begin
            req1 = 1; rw1 = rw; addr1 = addr; wdata1 = wd;
        end else begin
            req0 = 1; rw0 = rw; addr0 = addr; wdata0 = wd;
        end
        wait_ack(port, "ack_arrived");
        if (port) req1 = 0;
        else      req0 = 0;
    endtask

    task automatic wait_mem_req(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_req) got = 1;
        end
        chk(tag, got, 1);
    endtask

    initial begin
        logic [BW-1:0] all_ff;
        logic [BW-1:0] blk48;
        int            acks;
        all_ff = {16{8'hFF}};
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_err0", err0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_rw", mem_read_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Port 0 read of block 0, immediate memory response.
        do_req(1'b0, 1'b0, 10'h000, '0, pattern_blk(), 1'b0);
        @(negedge clk);
        chk("min_busy_len", last_busy_len, 1);

        // Port 1 write-through with unaligned address, then port 0 reads it back.
        do_req(1'b1, 1'b1, 10'h207, all_ff, '0, 1'b0);
        do_req(1'b0, 1'b0, 10'h200, '0, all_ff, 1'b0);

        // Watchdog: memory never answers.
        mem_stall = 1;
        do_req(1'b0, 1'b0, 10'h040, '0, '0, 1'b1);
        mem_stall = 0;
        @(negedge clk);
        chk("timeout_busy_len", last_busy_len, TO);
        do_req(1'b0, 1'b0, 10'h05C, 128'h1234, mem_blk[5], 1'b0);

        // Inputs change and req drops while BUSY.
        mem_lat = 5;
        @(negedge clk);
        exp_iss.push_back('{rw: 1'b0, addr: 10'h120, wd: 128'hABCD});
        exp_done.push_back('{port: 1'b0, err: 1'b0, rd: mem_blk[6'h12]});
        req0 = 1; rw0 = 0; addr0 = 10'h120; wdata0 = 128'hABCD;
        wait_mem_req("grant_seen_addr_test");
        repeat (2) @(negedge clk);
        addr0 = 10'h3F0; rw0 = 1; req0 = 0;
        wait_ack(1'b0, "ack_after_req_drop");
        repeat (5) begin
            @(negedge clk);
            chk("no_regrant", mem_req, 0);
        end
        mem_lat = 0;

        // Asynchronous reset in the middle of a stalled transaction.
        mem_stall = 1;
        @(negedge clk);
        exp_iss.push_back('{rw: 1'b0, addr: 10'h010, wd: '0});
        req0 = 1; rw0 = 0; addr0 = 10'h010; wdata0 = '0;
        wait_mem_req("grant_seen_rst_test");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_ack0", ack0, 0);
        chk("midrst_err0", err0, 0);
        chk("midrst_rdata0", rdata0, 0);
        req0 = 0;
        mem_stall = 0;
        @(negedge clk);
        rst_n = 1;

        // Both ports request continuously: grants alternate starting with port 0.
        blk48 = mem_blk[48];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_iss.push_back('{rw: 1'b0, addr: 10'h000, wd: '0});
            exp_iss.push_back('{rw: 1'b0, addr: 10'h300, wd: '0});
            exp_done.push_back('{port: 1'b0, err: 1'b0, rd: pattern_blk()});
            exp_done.push_back('{port: 1'b1, err: 1'b0, rd: blk48});
        end
        req0 = 1; rw0 = 0; addr0 = 10'h000; wdata0 = '0;
        req1 = 1; rw1 = 0; addr1 = 10'h300; wdata1 = '0;
        acks = 0;
        for (int i = 0; i < 200 && acks < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        req0 = 0; req1 = 0;
        chk("rr_ack_count", acks, 4);

        repeat (6) @(negedge clk);
        chk("issue_queue_drained", exp_iss.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory block port (10-bit byte address, 128-bit block) between two cache requesters: port 0 = instruction cache, port 1 = data cache.
- Serialises their block reads and write-throughs with round-robin arbitration and a ready handshake toward memory.
- Includes a watchdog timeout so a stalled memory cannot hang either cache.
- Sits between the cache controllers and the main-memory model.

Parameters:
- ADDR_W, 10, byte address width
- BLOCK_W, 128, memory block width (16 bytes)
- TIMEOUT, 16, max cycles in BUSY awaiting mem_ready; 0 disables watchdog

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  request per port
- rw0 / rw1  in  1  0 = read block, 1 = write block
- addr0 / addr1  in  ADDR_W  byte address; block-aligned internally, low 4 bits forced 0 on mem_addr
- wdata0 / wdata1  in  BLOCK_W  write block
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle pulse coincident with ack on timeout
- rdata0 / rdata1  out  BLOCK_W  read block, valid while ack high
- mem_req  out  1  memory access strobe
- mem_read_write  out  1  0 = read, 1 = write
- mem_addr  out  ADDR_W  block-aligned address
- mem_wdata  out  BLOCK_W  write data
- mem_rdata  in  BLOCK_W  read data, valid when mem_ready high
- mem_ready  in  1  memory completion, sampled only while mem_req high

Behaviour:
- Reset (async, rst_n low): state IDLE. All ack, err, mem_req, mem_read_write = 0. mem_addr, mem_wdata, rdata0, rdata1 = 0. last_grant = 1, so port 0 wins the first tie. Timeout counter = 0. Reset mid-transaction abandons it with no ack.
- IDLE: at a rising edge with any req high:
  - Pick the winner: a lone requester wins; if both request, the port != last_grant wins.
  - Latch the winner's rw, addr (low 4 bits cleared) and wdata into the mem_* registers.
  - Set grant and last_grant = winner; mem_req <= 1; counter <= 0; go to BUSY.
- BUSY: mem_req held high; mem_* outputs stable. Each edge:
  - If mem_ready = 1: on a read, capture mem_rdata into rdata of the granted port. mem_req <= 0; ack of the granted port <= 1; go to DONE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: mem_req <= 0; rdata of the granted port <= 0; ack and err of the granted port <= 1; go to DONE.
  - Else counter increments (saturating width clog2(TIMEOUT+1)).
- DONE: ack/err high for exactly this one cycle; next edge clears them and returns to IDLE. No arbitration happens in DONE.
- Requester rules:
  - req, rw, addr and wdata must be held until ack; inputs are latched at grant, so later changes are ignored.
  - Dropping req during BUSY does not abort; ack is still pulsed.
  - A req still high when IDLE next evaluates starts a new transaction. The requester must drop req within the cycle after ack.
- Minimum latency: req seen at edge E0, mem_ready high before E1 -> ack high during E1..E2. Back-to-back grants are separated by one IDLE cycle, so the minimum issue interval is 3 cycles.
- Non-granted port: ack/err stay 0; its rdata holds its last value.
- Write transactions leave rdata unchanged.
- mem_ready while mem_req is low is ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - ADDR_W, BLOCK_W, BLOCK_OFFSET_W = 4
  - state enum {IDLE, BUSY, DONE}
  - port-id constants PORT_I = 0, PORT_D = 1
- One sub-module, rr_arbiter2: combinational two-input round-robin pick from (req0, req1, last_grant) producing winner and valid. The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Reset, then port 0 only: read, addr 0x000, memory returns 0x00..0F pattern with mem_ready 1 cycle after mem_req -> mem_read_write = 0, mem_addr = 0x000, ack0 pulse 1 cycle, rdata0 = pattern, ack1 stays 0.
- Port 1 write: addr 0x207, wdata = all 0xFF -> mem_addr = 0x200, mem_read_write = 1, mem_wdata = all 0xFF, ack1 pulse. A subsequent port 0 read of 0x200 returns all 0xFF.
- Both ports request continuously (reads of 0x000 and 0x300) -> grant order 0, 1, 0, 1. Each ack is a single pulse, mem_req is never high for two ports at once, and issues are spaced at least 3 cycles apart.
- mem_ready held low, TIMEOUT = 16 -> exactly 16 BUSY cycles, then ack0 = err0 = 1 for one cycle, rdata0 = 0, FSM back to IDLE and serves the next request.
- Port 0 changes addr and drops req mid-BUSY -> mem_addr unchanged, ack0 still pulses, no new grant if req stays low.
- rst_n pulled low during BUSY (async, between edges) -> mem_req, ack, err immediately 0. After release, the first tie goes to port 0.
